// File: rtl/count_lim_pkg.sv
// -----------------------------------------------------------------------------
// count_pkg
//   Shared types for the count_lim limit counter.
//   mode_t  : end-of-range behaviour (wrap, saturate, one-shot; value 3 is
//             reserved and handled like saturate)
//   state_t : run / done state of the one-shot sequencer
// -----------------------------------------------------------------------------
package count_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/count_lim_if.sv
// -----------------------------------------------------------------------------
// count_lim_if
//   Control, configuration and status bundle of the count_lim counter.
//   master : the user of the counter (drives controls/limits, reads status)
//   slave  : the counter itself
//   Controls : clr, load, data_in, en, updn, step
//   Config   : lo_lim, hi_lim, mode
//   Status   : cnt, tc, ovf, done (registered), cfg_err (combinational)
// -----------------------------------------------------------------------------
interface count_lim_if #(
    parameter int BW = 10,
    parameter int SW = 4
);
    import count_pkg::*;

    logic          clr;
    logic          load;
    logic [BW-1:0] data_in;
    logic          en;
    logic          updn;
    logic [SW-1:0] step;
    logic [BW-1:0] lo_lim;
    logic [BW-1:0] hi_lim;
    mode_t         mode;

    logic [BW-1:0] cnt;
    logic          tc;
    logic          ovf;
    logic          done;
    logic          cfg_err;

    modport master (
        output clr, load, data_in, en, updn, step, lo_lim, hi_lim, mode,
        input  cnt, tc, ovf, done, cfg_err
    );

    modport slave (
        input  clr, load, data_in, en, updn, step, lo_lim, hi_lim, mode,
        output cnt, tc, ovf, done, cfg_err
    );

endinterface

// File: rtl/count_lim_nxt.sv
// -----------------------------------------------------------------------------
// count_lim_nxt
//   Combinational next-value logic of count_lim for one counting step.
//   Inputs : cnt (current value), step (magnitude), updn (0 up / 1 down),
//            lo_lim / hi_lim (inclusive limits), mode (end-of-range mode)
//   Outputs: nxt_cnt (value after the step, limit-handled)
//            evt     (step crossed a limit: over- or underflow)
// -----------------------------------------------------------------------------
module count_lim_nxt
    import count_pkg::*;
#(
    parameter int BW = 10,
    parameter int SW = 4
) (
    input  logic [BW-1:0] cnt,
    input  logic [SW-1:0] step,
    input  logic          updn,
    input  logic [BW-1:0] lo_lim,
    input  logic [BW-1:0] hi_lim,
    input  mode_t         mode,
    output logic [BW-1:0] nxt_cnt,
    output logic          evt
);

    logic [BW:0]   step_x;
    logic [BW-1:0] step_b;
    logic [BW:0]   sum_x;
    logic [BW:0]   thr_x;
    logic [BW-1:0] diff;
    logic          wrap;

    always_comb begin
        step_x  = (BW+1)'(step);
        step_b  = BW'(step);
        // One extra bit so that cnt + step and lo_lim + step cannot alias.
        sum_x   = {1'b0, cnt} + step_x;
        thr_x   = {1'b0, lo_lim} + step_x;
        diff    = cnt - step_b;
        wrap    = (mode == MODE_WRAP);
        evt     = 1'b0;
        nxt_cnt = cnt;

        if (!updn) begin
            evt = (sum_x > {1'b0, hi_lim});
            if (evt) begin
                nxt_cnt = wrap ? lo_lim : hi_lim;
            end else begin
                nxt_cnt = sum_x[BW-1:0];
            end
        end else begin
            // Underflow test avoids a negative intermediate: cnt < lo + step.
            evt = ({1'b0, cnt} < thr_x);
            if (evt) begin
                nxt_cnt = wrap ? hi_lim : lo_lim;
            end else begin
                nxt_cnt = diff;
            end
        end
    end

endmodule

// File: rtl/count_lim.sv
// -----------------------------------------------------------------------------
// count_lim
//   Loadable up/down counter with variable step, programmable inclusive
//   limits and wrap / saturate / one-shot end-of-range handling.
//   clk5m  : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : count_lim_if slave port
//            clr > load > count > hold priority each cycle
//            cnt/tc/ovf/done registered, cfg_err = lo_lim > hi_lim (comb.)
// -----------------------------------------------------------------------------
module count_lim
    import count_pkg::*;
#(
    parameter int BW = 10,
    parameter int SW = 4
) (
    input  logic        clk5m,
    input  logic        rst_n,
    count_lim_if.slave  bus
);

    logic [BW-1:0] cnt_q, cnt_d;
    logic          tc_q, tc_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    state_t        state_q, state_d;

    logic [BW-1:0] nxt_cnt;
    logic          evt;
    logic          cfg_err;
    logic          cnt_ok;

    function automatic logic [BW-1:0] clamp(input logic [BW-1:0] v,
                                            input logic [BW-1:0] lo,
                                            input logic [BW-1:0] hi);
        logic [BW-1:0] r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

    count_lim_nxt #(
        .BW (BW),
        .SW (SW)
    ) u_nxt (
        .cnt     (cnt_q),
        .step    (bus.step),
        .updn    (bus.updn),
        .lo_lim  (bus.lo_lim),
        .hi_lim  (bus.hi_lim),
        .mode    (bus.mode),
        .nxt_cnt (nxt_cnt),
        .evt     (evt)
    );

    assign cfg_err = (bus.lo_lim > bus.hi_lim);

    // Counting needs valid limits, a non-zero step and the run state.
    assign cnt_ok = bus.en && (bus.step != '0) && !cfg_err && (state_q == S_RUN);

    always_comb begin
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        done_d  = done_q;
        state_d = state_q;

        if (bus.clr) begin
            cnt_d   = bus.lo_lim;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
            state_d = S_RUN;
        end else if (bus.load && !cfg_err) begin
            cnt_d   = clamp(bus.data_in, bus.lo_lim, bus.hi_lim);
            ovf_d   = 1'b0;
            done_d  = 1'b0;
            state_d = S_RUN;
        end else if (cnt_ok) begin
            cnt_d = nxt_cnt;
            if (evt) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                if (bus.mode == MODE_ONESHOT) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            state_q <= S_RUN;
        end else begin
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.tc      = tc_q;
    assign bus.ovf     = ovf_q;
    assign bus.done    = done_q;
    assign bus.cfg_err = cfg_err;

endmodule

// File: tb/tb_count_lim.sv
// -----------------------------------------------------------------------------
// tb_count_lim
//   Directed scoreboard bench for count_lim (BW=10, SW=4). Each stimulus
//   cycle pushes the hand-computed post-edge state; a monitor pops and
//   compares shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_count_lim;
    import count_pkg::*;

    localparam int BW = 10;
    localparam int SW = 4;

    logic clk5m = 1'b0;
    logic rst_n = 1'b0;

    always #100 clk5m = ~clk5m;

    count_lim_if #(.BW(BW), .SW(SW)) bus ();

    count_lim #(.BW(BW), .SW(SW)) dut (
        .clk5m (clk5m),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string         nm;
        logic [BW-1:0] cnt;
        logic          tc;
        logic          ovf;
        logic          done;
        logic          cerr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rst_armed = 1'b0;

    task automatic cyc(input string nm, input int c, input bit tc,
                       input bit ovf, input bit done, input bit cerr);
        exp_t e;
        e.nm   = nm;
        e.cnt  = c[BW-1:0];
        e.tc   = tc;
        e.ovf  = ovf;
        e.done = done;
        e.cerr = cerr;
        sb.push_back(e);
        @(posedge clk5m);
        @(negedge clk5m);
    endtask

    // Scoreboard monitor
    always @(posedge clk5m) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (bus.cnt !== e.cnt || bus.tc !== e.tc || bus.ovf !== e.ovf ||
                bus.done !== e.done || bus.cfg_err !== e.cerr) begin
                n_bad++;
                $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b done=%0b cfg_err=%0b, expected cnt=%0d tc=%0b ovf=%0b done=%0b cfg_err=%0b",
                         e.nm, bus.cnt, bus.tc, bus.ovf, bus.done, bus.cfg_err,
                         e.cnt, e.tc, e.ovf, e.done, e.cerr);
            end
        end
    end

    // Reset must clear outputs without waiting for a clock edge.
    always @(negedge rst_n) begin
        if (rst_armed) begin
            #1;
            n_cmp++;
            if (bus.cnt !== '0 || bus.tc !== 1'b0 || bus.ovf !== 1'b0 || bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL async_rst: got cnt=%0d tc=%0b ovf=%0b done=%0b, expected all 0",
                         bus.cnt, bus.tc, bus.ovf, bus.done);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clr     = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = '0;
        bus.en      = 1'b0;
        bus.updn    = 1'b0;
        bus.step    = '0;
        bus.lo_lim  = '0;
        bus.hi_lim  = 10'd1023;
        bus.mode    = MODE_WRAP;

        repeat (2) @(negedge clk5m);
        rst_n     = 1'b1;
        rst_armed = 1'b1;
        cyc("rst_val", 0, 0, 0, 0, 0);

        // Count into an overflow, then reset mid-count
        bus.lo_lim = 10'd0; bus.hi_lim = 10'd4; bus.step = 4'd3; bus.en = 1'b1;
        cyc("cnt_a",    3, 0, 0, 0, 0);
        cyc("cnt_wrap", 0, 1, 1, 0, 0);
        cyc("cnt_b",    3, 0, 1, 0, 0);
        rst_n = 1'b0;
        cyc("rst_mid",  0, 0, 0, 0, 0);
        rst_n = 1'b1; bus.en = 1'b0; bus.lo_lim = 10'd5; bus.hi_lim = 10'd1023; bus.clr = 1'b1;
        cyc("clr",      5, 0, 0, 0, 0);
        bus.clr = 1'b0;

        // Wrap up
        bus.hi_lim = 10'd20; bus.data_in = 10'd18; bus.load = 1'b1;
        cyc("ld18",       18, 0, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1; bus.step = 4'd3; bus.updn = 1'b0; bus.mode = MODE_WRAP;
        cyc("wrap_up",     5, 1, 1, 0, 0);
        cyc("wrap_after",  8, 0, 1, 0, 0);

        // Saturate down with exact landing
        bus.en = 1'b0; bus.data_in = 10'd9; bus.load = 1'b1;
        cyc("ld9",        9, 0, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1; bus.step = 4'd4; bus.updn = 1'b1; bus.mode = MODE_SAT;
        cyc("sat_exact",  5, 0, 0, 0, 0);
        cyc("sat_evt1",   5, 1, 1, 0, 0);
        cyc("sat_evt2",   5, 1, 1, 0, 0);

        // One-shot
        bus.en = 1'b0; bus.lo_lim = 10'd0; bus.hi_lim = 10'd10; bus.data_in = 10'd9; bus.load = 1'b1;
        cyc("ld9b",      9, 0, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1; bus.step = 4'd2; bus.updn = 1'b0; bus.mode = MODE_ONESHOT;
        cyc("os_evt",   10, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            if (i >= 3) bus.mode = MODE_WRAP;
            cyc("os_hold", 10, 0, 1, 1, 0);
        end
        bus.load = 1'b1; bus.data_in = 10'd3;
        cyc("os_ld",     3, 0, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b0; bus.mode = MODE_WRAP;

        // Load clamp and priority
        bus.lo_lim = 10'd5; bus.hi_lim = 10'd20; bus.data_in = 10'd900; bus.load = 1'b1;
        bus.en = 1'b1; bus.step = 4'd2; bus.updn = 1'b0;
        cyc("clamp_hi", 20, 0, 0, 0, 0);
        bus.data_in = 10'd2;
        cyc("clamp_lo",  5, 0, 0, 0, 0);
        bus.clr = 1'b1; bus.data_in = 10'd12;
        cyc("clr_ld",    5, 0, 0, 0, 0);
        bus.clr = 1'b0; bus.lo_lim = 10'd30; bus.hi_lim = 10'd20; bus.data_in = 10'd25;
        cyc("cerr_ld",   5, 0, 0, 0, 1);
        bus.load = 1'b0;
        cyc("cerr_en",   5, 0, 0, 0, 1);

        // Step zero and full range wrap
        bus.lo_lim = 10'd0; bus.hi_lim = 10'd1023; bus.en = 1'b0; bus.load = 1'b1; bus.data_in = 10'd1020;
        cyc("ld1020",  1020, 0, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1; bus.step = 4'd0;
        cyc("step0",   1020, 0, 0, 0, 0);
        bus.step = 4'd15; bus.mode = MODE_WRAP; bus.updn = 1'b0;
        cyc("full_wrap",  0, 1, 1, 0, 0);

        // Exact landing on upper limit
        bus.en = 1'b0; bus.hi_lim = 10'd20; bus.load = 1'b1; bus.data_in = 10'd17;
        cyc("ld17",     17, 0, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1; bus.step = 4'd3;
        cyc("land_up",  20, 0, 0, 0, 0);

        // Down wrap reloads the upper limit
        bus.en = 1'b0; bus.lo_lim = 10'd5; bus.data_in = 10'd6; bus.load = 1'b1;
        cyc("ld6",       6, 0, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1; bus.step = 4'd4; bus.updn = 1'b1;
        cyc("wrap_dn",  20, 1, 1, 0, 0);

        // Reserved mode acts as saturate
        bus.en = 1'b0; bus.load = 1'b1; bus.data_in = 10'd19;
        cyc("ld19",     19, 0, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1; bus.step = 4'd3; bus.updn = 1'b0; bus.mode = MODE_RSVD;
        cyc("rsvd",     20, 1, 1, 0, 0);
        cyc("rsvd2",    20, 1, 1, 0, 0);

        // lo_lim == hi_lim: every step is an event
        bus.en = 1'b0; bus.lo_lim = 10'd7; bus.hi_lim = 10'd7; bus.clr = 1'b1;
        cyc("clr_eq",    7, 0, 0, 0, 0);
        bus.clr = 1'b0; bus.en = 1'b1; bus.step = 4'd1; bus.mode = MODE_SAT;
        cyc("eq_evt",    7, 1, 1, 0, 0);
        bus.en = 1'b0;

        repeat (2) @(negedge clk5m);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_lim.md
Name: count_lim

Overview:
Parametrised successor of the team's loadable up/down counter. Adds variable step size, programmable lower and upper limits, and three end-of-range modes: wrap, saturate and one-shot. Also adds terminal-count, sticky-overflow and done flags. Used as a generic timebase and event counter in the clk5m domain, for example for PWM periods, timeouts and address sequencing.

Parameters:
BW, 10, counter, data and limit width in bits (≥2)
SW, 4, step input width in bits (1..BW)

Ports:
clk5m  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear, highest priority after reset
load  input  1  synchronous load of data_in
data_in  input  BW  load value
en  input  1  count enable
updn  input  1  direction, 0 = up, 1 = down
step  input  SW  increment magnitude; 0 = hold
lo_lim  input  BW  lower count limit, inclusive
hi_lim  input  BW  upper count limit, inclusive
mode  input  2  end-of-range mode, type mode_t from count_pkg
cnt  output  BW  counter value (registered)
tc  output  1  terminal-count pulse (registered)
ovf  output  1  sticky over/underflow flag (registered)
done  output  1  one-shot finished (registered)
cfg_err  output  1  limits invalid, lo_lim > hi_lim (combinational)

Behaviour:
- Reset (asynchronous, rst_n=0): cnt=0, tc=0, ovf=0, done=0, FSM=S_RUN. Reset mid-operation aborts immediately. cnt=0 applies even if 0 lies outside the limits.
- All inputs are sampled at the rising edge of clk5m. Every output changes one cycle after the causing input edge.
- Priority per cycle: clr > load > count > hold.
- clr: cnt=lo_lim, ovf=0, done=0, FSM=S_RUN, tc=0.
- load:
  - cnt = data_in clamped into [lo_lim, hi_lim]; ovf=0, done=0, FSM=S_RUN, tc=0.
  - When cfg_err=1, load is ignored.
- Count condition: en=1, step≠0, cfg_err=0, FSM=S_RUN. Otherwise cnt holds and tc=0.
- Arithmetic: computed in BW+1 bits, with step zero-extended.
  - Overflow (up): cnt + step > hi_lim.
  - Underflow (down): cnt < lo_lim + step.
  - No event: cnt = cnt ± step.
- On an over/underflow event: tc=1 for that cycle, ovf=1 (sticky), then per mode:
  - MODE_WRAP (0): cnt reloads the opposite limit (up → lo_lim, down → hi_lim). Excess step is discarded.
  - MODE_SAT (1): cnt = reached limit (up → hi_lim, down → lo_lim). Further counting at the limit produces a new event and tc each cycle; cnt stays.
  - MODE_ONESHOT (2): cnt = reached limit, FSM → S_DONE, done=1. In S_DONE, en is ignored and tc=0. Only clr or load leaves S_DONE.
  - Value 3 is reserved and behaves as MODE_SAT.
- FSM states:
  - S_RUN: counting allowed.
  - S_DONE: counting frozen.
  - Transitions: S_RUN → S_DONE on a one-shot event; S_DONE → S_RUN on clr or load.
  - Changing mode while in S_DONE does not leave S_DONE.
- Exact landing on a limit (cnt + step == hi_lim) is not an event: no tc, no ovf.
- Limits and mode may change at any time; the new values take effect in the next evaluated cycle. After a limit change, cnt is not re-clamped until the next load, clr or event.
- cfg_err = (lo_lim > hi_lim), combinational.
- lo_lim == hi_lim is legal: every non-zero count step is an event.

Decomposition:
- Package count_pkg:
  - typedef enum logic [1:0] mode_t {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD}
  - typedef enum logic state_t {S_RUN, S_DONE}
- Sub-module count_lim_nxt (combinational):
  - Inputs: cnt, step, updn, lo_lim, hi_lim, mode.
  - Outputs: nxt_cnt, evt.
  - The top level holds the registers, FSM and priority logic.

Test Plan:
- Reset/clear: run at BW=10, SW=4. Drive rst_n=0 mid-count → cnt=0, flags 0. Then lo=5, clr=1 → cnt=5 next cycle.
- Wrap up: lo=5, hi=20, cnt=18, step=3, up, WRAP, en=1 → cnt=5, tc=1 for 1 cycle, ovf=1. Next cycle → cnt=8, tc=0, ovf=1.
- Saturate down with exact landing: lo=5, cnt=9, step=4, down, SAT → cnt=5, no tc. Next cycle → event, cnt=5, tc=1. Third cycle → tc=1 again.
- One-shot: lo=0, hi=10, cnt=9, step=2, up, ONESHOT → cnt=10, done=1, tc=1. Then en held high 5 cycles → cnt=10, tc=0. Then load=1, data_in=3 → cnt=3, done=0, ovf=0.
- Load clamp and priority:
  - lo=5, hi=20, data_in=900, load=1 with en=1 → cnt=20.
  - clr=1 and load=1 together → cnt=5.
  - lo=30, hi=20 → cfg_err=1; en and load both ignored, cnt holds.
- Step zero / full range: lo=0, hi=1023, cnt=1020, step=0, en=1 → cnt holds. Then step=15, up, WRAP → cnt=0, tc=1.
